// File: rtl/sync_fifo_param.sv
// rtl/sync_fifo_param.sv - single-clock parametrised FIFO with level, thresholds, flush and sticky errors
module sync_fifo_param #(
  parameter int WIDTH      = 8,
  parameter int DEPTH_LOG2 = 9,
  parameter int AF_THRESH  = 508,
  parameter int AE_THRESH  = 4
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  flush,
  input  logic                  clear_errors,
  input  logic                  write_enable,
  input  logic [WIDTH-1:0]      data_in,
  input  logic                  read_enable,
  output logic [WIDTH:0]        data_out,
  output logic [DEPTH_LOG2:0]   level,
  output logic                  empty,
  output logic                  full,
  output logic                  almost_empty,
  output logic                  almost_full,
  output logic                  overflow,
  output logic                  underflow
);

  localparam int DEPTH = 1 << DEPTH_LOG2;
  typedef logic [DEPTH_LOG2:0] ptr_t;
  localparam ptr_t AF_LEVEL = ptr_t'(AF_THRESH);
  localparam ptr_t AE_LEVEL = ptr_t'(AE_THRESH);
  localparam logic [WIDTH:0] MARKER = '1;

  logic [WIDTH-1:0] mem [DEPTH];
  ptr_t             wr_ptr;
  ptr_t             rd_ptr;
  ptr_t             level_q;
  logic             rd_ok;
  logic             wr_ok;

  // Extra pointer bit distinguishes full from empty so every slot is usable.
  assign empty        = (wr_ptr == rd_ptr);
  assign full         = (wr_ptr[DEPTH_LOG2] != rd_ptr[DEPTH_LOG2]) &&
                        (wr_ptr[DEPTH_LOG2-1:0] == rd_ptr[DEPTH_LOG2-1:0]);
  assign level        = level_q;
  assign almost_empty = (level_q <= AE_LEVEL);
  assign almost_full  = (level_q >= AF_LEVEL);

  assign rd_ok = read_enable && !empty;
  assign wr_ok = write_enable && (!full || rd_ok);

  // Write port kept free of reset so the array maps onto block RAM.
  always_ff @(posedge clock) begin
    if (!reset && !flush && wr_ok) begin
      mem[wr_ptr[DEPTH_LOG2-1:0]] <= data_in;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      level_q   <= '0;
      data_out  <= MARKER;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      if (flush) begin
        wr_ptr   <= '0;
        rd_ptr   <= '0;
        level_q  <= '0;
        data_out <= MARKER;
      end else begin
        if (rd_ok) begin
          data_out <= {1'b0, mem[rd_ptr[DEPTH_LOG2-1:0]]};
          rd_ptr   <= rd_ptr + ptr_t'(1);
        end else if (read_enable) begin
          data_out <= MARKER;
        end
        if (wr_ok) begin
          wr_ptr <= wr_ptr + ptr_t'(1);
        end
        level_q <= level_q + ptr_t'(wr_ok) - ptr_t'(rd_ok);
      end

      // A fresh error in the same cycle as clear_errors keeps the flag set.
      if (clear_errors) begin
        overflow  <= 1'b0;
        underflow <= 1'b0;
      end
      if (!flush && write_enable && !wr_ok) begin
        overflow <= 1'b1;
      end
      if (!flush && read_enable && empty) begin
        underflow <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_sync_fifo_param.sv
// tb/tb_sync_fifo_param.sv - scoreboard bench for sync_fifo_param with directed vectors
module tb_sync_fifo_param;

  localparam int W   = 8;
  localparam int DL  = 4;
  localparam int CAP = 16;

  logic         clock = 1'b0;
  logic         reset = 1'b1;
  logic         flush = 1'b0;
  logic         clear_errors = 1'b0;
  logic         write_enable = 1'b0;
  logic [W-1:0] data_in = '0;
  logic         read_enable = 1'b0;
  logic [W:0]   data_out;
  logic [DL:0]  level;
  logic         empty, full, almost_empty, almost_full, overflow, underflow;

  sync_fifo_param #(
    .WIDTH(W), .DEPTH_LOG2(DL), .AF_THRESH(14), .AE_THRESH(1)
  ) dut (
    .clock(clock), .reset(reset), .flush(flush), .clear_errors(clear_errors),
    .write_enable(write_enable), .data_in(data_in), .read_enable(read_enable),
    .data_out(data_out), .level(level), .empty(empty), .full(full),
    .almost_empty(almost_empty), .almost_full(almost_full),
    .overflow(overflow), .underflow(underflow)
  );

  always #5 clock = ~clock;

  int         vectors = 0;
  int         miscompares = 0;
  logic [W:0] expq[$];
  int         mq[$];
  bit         mov = 0;
  bit         mund = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chk_status();
    chk("level", 32'(level), mq.size());
    chk("empty", 32'(empty), 32'(mq.size() == 0));
    chk("full", 32'(full), 32'(mq.size() == CAP));
    chk("almost_empty", 32'(almost_empty), 32'(mq.size() <= 1));
    chk("almost_full", 32'(almost_full), 32'(mq.size() >= 14));
    chk("overflow", 32'(overflow), 32'(mov));
    chk("underflow", 32'(underflow), 32'(mund));
  endtask

  // One clock of stimulus; the model decides what data_out must show next.
  task automatic step(input bit we, input logic [W-1:0] din, input bit re,
                      input bit fl, input bit ce);
    bit rd_ok, wr_ok;
    write_enable = we; data_in = din; read_enable = re;
    flush = fl; clear_errors = ce;
    if (ce) begin
      mov = 0; mund = 0;
    end
    if (fl) begin
      mq.delete();
      expq.push_back(9'h1FF);
    end else begin
      rd_ok = re && (mq.size() > 0);
      wr_ok = we && ((mq.size() < CAP) || rd_ok);
      if (re) begin
        if (rd_ok) expq.push_back({1'b0, 8'(mq.pop_front())});
        else begin
          expq.push_back(9'h1FF);
          mund = 1;
        end
      end
      if (we) begin
        if (wr_ok) mq.push_back(int'(din));
        else mov = 1;
      end
    end
    @(posedge clock); #1;
    chk_status();
  endtask

  task automatic do_reset(input bit we, input bit re);
    reset = 1'b1; write_enable = we; read_enable = re; flush = 0; clear_errors = 0;
    data_in = 8'hEE;
    mq.delete(); mov = 0; mund = 0;
    @(posedge clock); #1;
    chk("reset_data_out", 32'(data_out), 32'h1FF);
    chk_status();
    reset = 1'b0;
  endtask

  task automatic idle();
    write_enable = 0; read_enable = 0; flush = 0; clear_errors = 0;
  endtask

  // Monitor: each read or flush accepted on an edge owes one data_out check.
  initial begin
    bit r, f, rs;
    logic [W:0] e;
    forever begin
      @(posedge clock);
      r = read_enable; f = flush; rs = reset;
      @(negedge clock);
      if (!rs && (r || f)) begin
        if (expq.size() == 0) begin
          vectors++;
          miscompares++;
          $display("FAIL data_out_unexpected: got %0h expected none", data_out);
        end else begin
          e = expq.pop_front();
          chk("data_out", 32'(data_out), 32'(e));
        end
      end
    end
  end

  initial begin
    #200000;
    miscompares++;
    $display("FAIL watchdog: got timeout expected completion");
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    repeat (2) @(posedge clock);
    #1;
    do_reset(0, 0);

    step(0, 8'h00, 1, 0, 0);                       // read while empty
    for (int i = 0; i < CAP; i++) step(1, 8'(i), 0, 0, 0);
    step(1, 8'hAA, 0, 0, 0);                       // dropped
    for (int i = 0; i < CAP; i++) step(0, 8'h00, 1, 0, 0);

    for (int i = 0; i < 40; i++)
      step(1, 8'(8'h20 + i), (i >= 3) && (i % 4 != 1), 0, 0);
    while (mq.size() > 0) step(0, 8'h00, 1, 0, 0);

    for (int i = 0; i < CAP; i++) step(1, 8'(8'h60 + i), 0, 0, 0);
    step(1, 8'h55, 1, 0, 0);                       // full + read + write
    for (int i = 0; i < CAP; i++) step(0, 8'h00, 1, 0, 0);

    step(1, 8'h91, 1, 0, 0);                       // empty + read + write
    step(0, 8'h00, 1, 0, 0);

    for (int i = 0; i < 5; i++) step(1, 8'(8'hC0 + i), 0, 0, 0);
    step(1, 8'h77, 1, 1, 0);                       // flush beats read/write

    step(0, 8'h00, 0, 0, 1);
    step(0, 8'h00, 1, 0, 0);
    step(0, 8'h00, 1, 0, 1);                       // new underflow wins
    step(0, 8'h00, 0, 0, 1);

    for (int i = 0; i < 3; i++) step(1, 8'(8'hD0 + i), 0, 0, 0);
    step(1, 8'hD3, 1, 0, 0);
    do_reset(1, 1);                                // mid-burst reset
    step(1, 8'h42, 0, 0, 0);
    step(0, 8'h00, 1, 0, 0);

    idle();
    repeat (3) @(posedge clock);
    #1;
    chk("scoreboard_drained", 32'(expq.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
